// File: rtl/mul8_pp_gen_if.sv
// Stream interface for the 8x8 partial-product feeder: operand/tag input
// stream on one side, 15 column bundles plus tag on the other.
interface mul8_pp_gen_if #(
  parameter int TAG_W = 4
);
  logic             in_valid;
  logic             in_ready;
  logic [7:0]       in_a;
  logic [7:0]       in_b;
  logic [TAG_W-1:0] in_tag;

  logic             out_valid;
  logic             out_ready;
  logic [0:0]       pp0;
  logic [1:0]       pp1;
  logic [2:0]       pp2;
  logic [3:0]       pp3;
  logic [4:0]       pp4;
  logic [5:0]       pp5;
  logic [6:0]       pp6;
  logic [7:0]       pp7;
  logic [6:0]       pp8;
  logic [5:0]       pp9;
  logic [4:0]       pp10;
  logic [3:0]       pp11;
  logic [2:0]       pp12;
  logic [1:0]       pp13;
  logic [0:0]       pp14;
  logic [TAG_W-1:0] out_tag;

  // Upstream/downstream environment view.
  modport master (
    output in_valid, in_a, in_b, in_tag, out_ready,
    input  in_ready, out_valid, out_tag,
    input  pp0, pp1, pp2, pp3, pp4, pp5, pp6, pp7,
    input  pp8, pp9, pp10, pp11, pp12, pp13, pp14
  );

  // Feeder view.
  modport slave (
    input  in_valid, in_a, in_b, in_tag, out_ready,
    output in_ready, out_valid, out_tag,
    output pp0, pp1, pp2, pp3, pp4, pp5, pp6, pp7,
    output pp8, pp9, pp10, pp11, pp12, pp13, pp14
  );
endinterface

// File: rtl/mul8_pp_gen.sv
// 8x8 unsigned partial-product generator: forms the 64 AND bits grouped by
// column and buffers them in a 2-entry registered FIFO for the compressor.
module mul8_pp_gen #(
  parameter int TAG_W = 4
) (
  input  logic               clk,
  input  logic               rst,
  mul8_pp_gen_if.slave       bus
);
  localparam int PP_W = 64;

  function automatic int col_w(input int k);
    return (k <= 7) ? k + 1 : 15 - k;
  endfunction

  // Packed offset of column k: columns laid out back to back, pp0 at bit 0.
  function automatic int col_off(input int k);
    int s;
    s = 0;
    for (int m = 0; m < k; m++) s += col_w(m);
    return s;
  endfunction

  logic [PP_W-1:0]  pp_in;

  logic [1:0]       count_reg, count_next;
  logic [PP_W-1:0]  head_pp_reg, head_pp_next;
  logic [PP_W-1:0]  tail_pp_reg, tail_pp_next;
  logic [TAG_W-1:0] head_tag_reg, head_tag_next;
  logic [TAG_W-1:0] tail_tag_reg, tail_tag_next;

  logic in_ready;
  logic out_valid;
  logic push;
  logic pop;

  // Bit n of column K is a[i]&b[K-i] with n = i - max(0, K-7).
  generate
    for (genvar gi = 0; gi < 8; gi++) begin : g_a
      for (genvar gj = 0; gj < 8; gj++) begin : g_b
        localparam int K = gi + gj;
        localparam int N = gi - ((K > 7) ? K - 7 : 0);
        assign pp_in[col_off(K) + N] = bus.in_a[gi] & bus.in_b[gj];
      end
    end
  endgenerate

  assign in_ready  = (count_reg < 2'd2);
  assign out_valid = (count_reg != 2'd0);
  assign push      = bus.in_valid & in_ready;
  assign pop       = out_valid & bus.out_ready;

  always_comb begin
    count_next    = count_reg;
    head_pp_next  = head_pp_reg;
    head_tag_next = head_tag_reg;
    tail_pp_next  = tail_pp_reg;
    tail_tag_next = tail_tag_reg;
    case (count_reg)
      2'd0: begin
        if (push) begin
          head_pp_next  = pp_in;
          head_tag_next = bus.in_tag;
          count_next    = 2'd1;
        end
      end
      2'd1: begin
        case ({push, pop})
          2'b11: begin
            head_pp_next  = pp_in;
            head_tag_next = bus.in_tag;
          end
          2'b10: begin
            tail_pp_next  = pp_in;
            tail_tag_next = bus.in_tag;
            count_next    = 2'd2;
          end
          2'b01:   count_next = 2'd0;
          default: count_next = 2'd1;
        endcase
      end
      2'd2: begin
        // Full: no push possible, a pop promotes the tail entry.
        if (pop) begin
          head_pp_next  = tail_pp_reg;
          head_tag_next = tail_tag_reg;
          count_next    = 2'd1;
        end
      end
      default: count_next = 2'd0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      count_reg    <= 2'd0;
      head_pp_reg  <= '0;
      head_tag_reg <= '0;
      tail_pp_reg  <= '0;
      tail_tag_reg <= '0;
    end else begin
      count_reg    <= count_next;
      head_pp_reg  <= head_pp_next;
      head_tag_reg <= head_tag_next;
      tail_pp_reg  <= tail_pp_next;
      tail_tag_reg <= tail_tag_next;
    end
  end

  assign bus.in_ready  = in_ready;
  assign bus.out_valid = out_valid;
  assign bus.out_tag   = head_tag_reg;

  assign bus.pp0  = head_pp_reg[col_off(0)  +: 1];
  assign bus.pp1  = head_pp_reg[col_off(1)  +: 2];
  assign bus.pp2  = head_pp_reg[col_off(2)  +: 3];
  assign bus.pp3  = head_pp_reg[col_off(3)  +: 4];
  assign bus.pp4  = head_pp_reg[col_off(4)  +: 5];
  assign bus.pp5  = head_pp_reg[col_off(5)  +: 6];
  assign bus.pp6  = head_pp_reg[col_off(6)  +: 7];
  assign bus.pp7  = head_pp_reg[col_off(7)  +: 8];
  assign bus.pp8  = head_pp_reg[col_off(8)  +: 7];
  assign bus.pp9  = head_pp_reg[col_off(9)  +: 6];
  assign bus.pp10 = head_pp_reg[col_off(10) +: 5];
  assign bus.pp11 = head_pp_reg[col_off(11) +: 4];
  assign bus.pp12 = head_pp_reg[col_off(12) +: 3];
  assign bus.pp13 = head_pp_reg[col_off(13) +: 2];
  assign bus.pp14 = head_pp_reg[col_off(14) +: 1];
endmodule

// File: tb/tb_mul8_pp_gen.sv
// Scoreboarded bench for mul8_pp_gen: directed corner cases plus random
// traffic, checked against an arithmetic model of the column rules.
module tb_mul8_pp_gen;
  localparam int TAG_W = 4;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  mul8_pp_gen_if #(.TAG_W(TAG_W)) bus ();
  mul8_pp_gen #(.TAG_W(TAG_W)) dut (.clk(clk), .rst(rst), .bus(bus));

  typedef struct {
    logic [7:0]       a;
    logic [7:0]       b;
    logic [TAG_W-1:0] tag;
  } txn_t;

  txn_t exp_q[$];
  int   n_checks = 0;
  int   n_pass   = 0;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  function automatic int col_w(input int k);
    return (k <= 7) ? k + 1 : 15 - k;
  endfunction

  function automatic logic [7:0] act_col(input int k);
    case (k)
      0:  return 8'(bus.pp0);
      1:  return 8'(bus.pp1);
      2:  return 8'(bus.pp2);
      3:  return 8'(bus.pp3);
      4:  return 8'(bus.pp4);
      5:  return 8'(bus.pp5);
      6:  return 8'(bus.pp6);
      7:  return 8'(bus.pp7);
      8:  return 8'(bus.pp8);
      9:  return 8'(bus.pp9);
      10: return 8'(bus.pp10);
      11: return 8'(bus.pp11);
      12: return 8'(bus.pp12);
      13: return 8'(bus.pp13);
      default: return 8'(bus.pp14);
    endcase
  endfunction

  // All columns, 8 bits per slot (slot k at [8k+7:8k]).
  function automatic logic [127:0] act_cols();
    logic [127:0] r;
    r = '0;
    for (int k = 0; k < 15; k++) r[k*8 +: 8] = act_col(k);
    return r;
  endfunction

  function automatic logic [127:0] model_cols(input logic [7:0] a, input logic [7:0] b);
    logic [127:0] r;
    int i;
    r = '0;
    for (int k = 0; k < 15; k++)
      for (int n = 0; n < col_w(k); n++) begin
        i = n + ((k > 7) ? k - 7 : 0);
        r[k*8 + n] = a[i] & b[k - i];
      end
    return r;
  endfunction

  function automatic logic [15:0] cols_value(input logic [127:0] c);
    logic [15:0] p;
    p = '0;
    for (int k = 0; k < 15; k++)
      for (int n = 0; n < 8; n++)
        if (c[k*8 + n]) p = p + (16'd1 << k);
    return p;
  endfunction

  // Monitor: pops the scoreboard on every output handshake, checks hold under stall.
  logic             hold_pending = 1'b0;
  logic [127:0]     held_cols;
  logic [TAG_W-1:0] held_tag;

  always @(negedge clk) begin
    txn_t t;
    logic [127:0] c;
    if (rst) begin
      hold_pending = 1'b0;
    end else begin
      c = act_cols();
      if (hold_pending) begin
        check("hold_valid", 128'(bus.out_valid), 128'd1);
        check("hold_cols", c, held_cols);
        check("hold_tag", 128'(bus.out_tag), 128'(held_tag));
      end
      if (bus.out_valid && bus.out_ready) begin
        if (exp_q.size() == 0) begin
          check("spurious_out_valid", 128'(bus.out_valid), 128'd0);
        end else begin
          t = exp_q.pop_front();
          check("out_tag", 128'(bus.out_tag), 128'(t.tag));
          check("pp_cols", c, model_cols(t.a, t.b));
          check("pp_product", 128'(cols_value(c)), 128'(16'(t.a * t.b)));
          $display("txn tag=%0d a=%02h b=%02h product=%04h", bus.out_tag, t.a, t.b, cols_value(c));
        end
      end
      hold_pending = bus.out_valid && !bus.out_ready;
      held_cols    = c;
      held_tag     = bus.out_tag;
    end
  end

  // One clock: record a push just before the edge, return 1ns after it.
  task automatic cycle(output bit accepted);
    txn_t t;
    @(negedge clk);
    accepted = bus.in_valid && bus.in_ready && !rst;
    if (accepted) begin
      t.a = bus.in_a;
      t.b = bus.in_b;
      t.tag = bus.in_tag;
      exp_q.push_back(t);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [7:0] a, input logic [7:0] b, input logic [TAG_W-1:0] tag);
    bus.in_valid = 1'b1;
    bus.in_a     = a;
    bus.in_b     = b;
    bus.in_tag   = tag;
  endtask

  logic [7:0] dir_a [3] = '{8'h01, 8'h80, 8'h02};
  logic [7:0] dir_b [3] = '{8'h80, 8'h01, 8'h80};
  int         dir_bit [3] = '{56, 63, 64};

  initial begin
    bit ok;
    int acc;
    int cyc;
    bit pend;
    logic [127:0] one;

    rst = 1'b1;
    bus.in_valid = 1'b0;
    bus.in_a = '0;
    bus.in_b = '0;
    bus.in_tag = '0;
    bus.out_ready = 1'b0;
    @(posedge clk);
    #1;
    repeat (3) cycle(ok);
    rst = 1'b0;

    check("reset_out_valid", 128'(bus.out_valid), 128'd0);
    check("reset_in_ready", 128'(bus.in_ready), 128'd1);
    check("reset_cols", act_cols(), 128'd0);
    check("reset_out_tag", 128'(bus.out_tag), 128'd0);

    // All-ones operands: every partial-product bit set.
    bus.out_ready = 1'b1;
    drive(8'hFF, 8'hFF, 4'd1);
    cycle(ok);
    bus.in_valid = 1'b0;
    check("ff_latency_valid", 128'(bus.out_valid), 128'd1);
    check("ff_popcount", 128'($countones(act_cols())), 128'd64);
    cycle(ok);

    // Single-bit corners of columns 7 and 8.
    for (int d = 0; d < 3; d++) begin
      drive(dir_a[d], dir_b[d], 4'(d + 2));
      cycle(ok);
      bus.in_valid = 1'b0;
      one = 128'd1 << dir_bit[d];
      check("single_bit_cols", act_cols(), one);
    end
    cycle(ok);

    // Backpressure: fill, stall, release one slot.
    bus.out_ready = 1'b0;
    drive(8'($urandom), 8'($urandom), 4'd1);
    cycle(ok);
    drive(8'($urandom), 8'($urandom), 4'd2);
    cycle(ok);
    check("bp_full_in_ready", 128'(bus.in_ready), 128'd0);
    drive(8'($urandom), 8'($urandom), 4'd3);
    cycle(ok);
    check("bp_tag3_held", 128'(ok), 128'd0);
    check("bp_head_tag1", 128'(bus.out_tag), 128'd1);
    bus.out_ready = 1'b1;
    cycle(ok);
    bus.out_ready = 1'b0;
    check("bp_head_tag2", 128'(bus.out_tag), 128'd2);
    check("bp_in_ready_back", 128'(bus.in_ready), 128'd1);
    cycle(ok);
    check("bp_tag3_accepted", 128'(ok), 128'd1);
    bus.in_valid = 1'b0;
    bus.out_ready = 1'b1;
    repeat (3) cycle(ok);

    // Streaming at count=1: push and pop every cycle.
    drive(8'($urandom), 8'($urandom), 4'd0);
    cycle(ok);
    for (int s = 1; s <= 10; s++) begin
      drive(8'($urandom), 8'($urandom), 4'(s));
      cycle(ok);
      check("stream_out_valid", 128'(bus.out_valid), 128'd1);
      check("stream_in_ready", 128'(bus.in_ready), 128'd1);
    end
    bus.in_valid = 1'b0;
    cycle(ok);
    check("stream_drained", 128'(bus.out_valid), 128'd0);

    // Reset while full with a pending input.
    bus.out_ready = 1'b0;
    drive(8'($urandom), 8'($urandom), 4'd7);
    cycle(ok);
    drive(8'($urandom), 8'($urandom), 4'd8);
    cycle(ok);
    drive(8'($urandom), 8'($urandom), 4'd6);
    rst = 1'b1;
    cycle(ok);
    rst = 1'b0;
    exp_q.delete();
    bus.in_valid = 1'b0;
    check("rst_out_valid", 128'(bus.out_valid), 128'd0);
    check("rst_in_ready", 128'(bus.in_ready), 128'd1);
    check("rst_cols", act_cols(), 128'd0);
    bus.out_ready = 1'b1;
    drive(8'hA5, 8'h3C, 4'd9);
    cycle(ok);
    bus.in_valid = 1'b0;
    check("post_rst_product", 128'(cols_value(act_cols())), 128'h26AC);
    cycle(ok);

    // Random traffic: random valid/ready, held data while stalled.
    acc = 0;
    cyc = 0;
    pend = 1'b0;
    while (acc < 1000 && cyc < 20000) begin
      if (!pend) begin
        bus.in_valid = ($urandom_range(0, 3) != 0);
        bus.in_a     = 8'($urandom);
        bus.in_b     = 8'($urandom);
        bus.in_tag   = TAG_W'($urandom);
      end
      bus.out_ready = ($urandom_range(0, 3) != 0);
      cycle(ok);
      if (ok) acc++;
      pend = bus.in_valid && !ok;
      cyc++;
    end
    check("random_accepted", 128'(acc), 128'd1000);

    bus.in_valid = 1'b0;
    bus.out_ready = 1'b1;
    for (int w = 0; w < 10 && exp_q.size() > 0; w++) cycle(ok);
    check("drain_scoreboard_empty", 128'(exp_q.size()), 128'd0);
    check("drain_out_valid", 128'(bus.out_valid), 128'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule

// File: doc/mul8_pp_gen.md
Name: mul8_pp_gen

Overview:
Upstream feeder for the 8x8 unsigned multiplier compressor tree. It accepts operand pairs over a valid/ready handshake and forms the 64 AND partial-product bits. The bits are arranged into 15 column bundles, pp0..pp14, whose widths match the compressor's src0..src14 inputs. A 2-entry elastic buffer registers the bundles, so the combinational compressor sees registered inputs and backpressure does not drop operands.

Parameters:
TAG_W, 4, width of the opaque sideband tag carried alongside each operand pair (minimum 1)

Ports:
clk  input  1  clock; all state updates on the rising edge
rst  input  1  synchronous active-high reset
in_valid  input  1  operand pair present
in_ready  output  1  block can accept this cycle
in_a  input  8  multiplicand, unsigned
in_b  input  8  multiplier, unsigned
in_tag  input  TAG_W  sideband, passed through unchanged
out_valid  output  1  pp bundle present
out_ready  input  1  downstream accepts this cycle
ppK  output  K+1 for K=0..7, 15-K for K=8..14  column K bits (pp0 1b ... pp7 8b ... pp14 1b)
out_tag  output  TAG_W  tag of the bundle on pp0..pp14

Behaviour:
- Column mapping: column K holds a[i]&b[j] for all i+j=K. Bit index within ppK is n = i - max(0, K-7), so bits are ordered by ascending i.
  - Example: pp7[0]=a0&b7 and pp7[7]=a7&b0.
  - Example: pp8[0]=a1&b7.
- AND generation happens on the input side. Registered bits (64 pp bits + TAG_W) are stored per entry, not the raw operands.
- Storage: 2-entry FIFO with head entry driving the outputs directly from flops; no combinational path from in_* to out_*.
  - Occupancy count is 0..2.
- Handshake:
  - Push when in_valid&in_ready; pop when out_valid&out_ready.
  - in_ready = (count<2). It depends only on registered state and must not depend on out_ready.
  - out_valid = (count>0).
  - Payload on out_* is held stable while out_valid=1 and out_ready=0.
- Latency: an accepted pair appears on out_* the cycle after acceptance when the FIFO was empty, or later, in order, behind earlier entries.
- Throughput: one pair per cycle sustained when out_ready=1.
- Simultaneous push and pop:
  - count=1: count stays 1. The head is replaced by the new entry on the next edge.
  - count=2: in_ready=0, so no push occurs. The pop frees one slot; in_ready rises the next cycle.
- Push with count=0: the entry goes to the head, count becomes 1.
- Pop with count=2: the second entry moves to the head, count becomes 1.
- in_valid while in_ready=0 is ignored; the upstream must hold its data.
- Reset (synchronous, takes priority over push/pop on the same edge):
  - count=0, out_valid=0, in_ready=1.
  - pp0..pp14=0, out_tag=0.
  - Entries in flight at reset are discarded. No partial bundle is ever presented.
- X on in_a/in_b/in_tag while in_valid=0 must not reach the outputs. Entry registers load only on push.
- Output values are undefined-free: unused storage is cleared to 0 on reset.

Test Plan:
- After reset: out_valid=0, in_ready=1, all pp*=0. Push a=0xFF, b=0xFF with out_ready=1 -> next cycle out_valid=1, every bit of pp0..pp14 =1, and the popcount of all pp bits is 64.
- Push a=0x01, b=0x80 -> only pp7[0]=1. Push a=0x80, b=0x01 -> only pp7[7]=1. Push a=0x02, b=0x80 -> only pp8[0]=1. All other bits are 0 in each case.
- Randomised 1000 pairs with random in_valid and out_ready; scoreboard the tags. Summing ppK bits x 2^K must equal a*b (e.g. 0xA5*0x3C=0x26AC), with tag order preserved and no loss or duplication.
- Backpressure: out_ready=0, push tags 1,2,3 back-to-back -> tags 1 and 2 accepted, in_ready=0 from the cycle after the 2nd push, tag 3 held. Output shows tag 1 stable. Raise out_ready for 1 cycle -> tag 2 at head, in_ready=1 the following cycle, tag 3 accepted.
- Simultaneous push and pop at count=1 for 10 cycles -> count remains 1, out_valid continuous, tags emerge one per cycle in order.
- Assert rst for one cycle with count=2 and in_valid=1 -> next cycle count=0, out_valid=0, pp*=0, in_ready=1. The next push emerges with correct products and none of the pre-reset tags appears.
